// File: rtl/cpu_top.sv
// UART-driven GCD calculator: two received bytes A and B, GCD sent back over UART and shown on 7-seg digits.
// Optional macro LED_STATUS_EN turns the LED bank into a status display instead of the last result.
module cpu_top #(
  parameter int BAUD_DIV = 5208
) (
  input  logic       sysclk,
  input  logic       reset,
  output logic [7:0] led,
  input  logic [7:0] switch,
  output logic [6:0] digi1,
  output logic [6:0] digi2,
  output logic [6:0] digi3,
  output logic [6:0] digi4,
  input  logic       UART_RX,
  output logic       UART_TX
);

  localparam int CW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] BIT_END  = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_END = CW'(BAUD_DIV / 2 - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [1:0] {IDLE, HAVE_A, CALC, SEND} state_e;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      4'hF: hex7 = 7'h0E;
      default: hex7 = 7'h7F;
    endcase
  endfunction

  logic          rx_s1_q, rx_s2_q, rx_prev_q, sw_s1_q, sw_s2_q;
  rx_state_e     rx_st_q, rx_st_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_idx_q, rx_idx_d;
  logic [7:0]    rx_sh_q, rx_sh_d;
  logic          rx_vld_q, rx_vld_d, ferr_q, ferr_d;

  state_e        st_q, st_d;
  logic [7:0]    a_q, a_d, b_q, b_d, x_q, x_d, y_q, y_d, res_q, res_d;
  logic          a_vld_q, a_vld_d, b_vld_q, b_vld_d, res_vld_q, res_vld_d;
  logic [9:0]    tx_sh_q, tx_sh_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [3:0]    tx_idx_q, tx_idx_d;
  logic          tx_q, tx_d;
  logic          calc_done_s;
  logic [7:0]    gcd_s, sel_s;
  logic          sel_vld_s;
  logic [7:0]    led_q, led_d;
  logic [6:0]    dig1_q, dig1_d, dig2_q, dig2_d, dig3_q, dig3_d, dig4_q, dig4_d;
  logic          unused_sw_s;

  assign unused_sw_s = ^switch[7:1];

  // RX: edge detect, mid-start recheck, mid-bit data sampling, stop-bit validation
  always_comb begin
    rx_st_d  = rx_st_q;
    rx_cnt_d = rx_cnt_q;
    rx_idx_d = rx_idx_q;
    rx_sh_d  = rx_sh_q;
    rx_vld_d = 1'b0;
    ferr_d   = ferr_q;
    case (rx_st_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_s2_q) begin
          rx_st_d  = RX_START;
          rx_cnt_d = {CW{1'b0}};
        end else begin
          rx_st_d = RX_IDLE;
        end
      end
      RX_START: begin
        if (rx_cnt_q == HALF_END) begin
          rx_cnt_d = {CW{1'b0}};
          rx_idx_d = 3'd0;
          rx_st_d  = rx_s2_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BIT_END) begin
          rx_cnt_d = {CW{1'b0}};
          rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
          rx_idx_d = rx_idx_q + 3'd1;
          if (rx_idx_q == 3'd7) begin
            rx_st_d = RX_STOP;
          end else begin
            rx_st_d = RX_DATA;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == BIT_END) begin
          rx_st_d = RX_IDLE;
          if (rx_s2_q) begin
            rx_vld_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      default: rx_st_d = RX_IDLE;
    endcase
  end

  // Control FSM: operand capture, subtractive GCD, TX framing
  always_comb begin
    st_d        = st_q;
    a_d         = a_q;
    b_d         = b_q;
    a_vld_d     = a_vld_q;
    b_vld_d     = b_vld_q;
    x_d         = x_q;
    y_d         = y_q;
    res_d       = res_q;
    res_vld_d   = res_vld_q;
    tx_sh_d     = tx_sh_q;
    tx_cnt_d    = tx_cnt_q;
    tx_idx_d    = tx_idx_q;
    calc_done_s = 1'b0;
    gcd_s       = x_q;
    case (st_q)
      IDLE: begin
        if (rx_vld_q) begin
          a_d     = rx_sh_q;
          a_vld_d = 1'b1;
          b_vld_d = 1'b0;
          st_d    = HAVE_A;
        end else begin
          st_d = IDLE;
        end
      end
      HAVE_A: begin
        if (rx_vld_q) begin
          b_d     = rx_sh_q;
          b_vld_d = 1'b1;
          x_d     = a_q;
          y_d     = rx_sh_q;
          st_d    = CALC;
        end else begin
          st_d = HAVE_A;
        end
      end
      CALC: begin
        // Zero operands and equal operands all finish in a single step
        if (x_q == 8'd0) begin
          calc_done_s = 1'b1;
          gcd_s       = y_q;
        end else if ((y_q == 8'd0) || (x_q == y_q)) begin
          calc_done_s = 1'b1;
          gcd_s       = x_q;
        end else if (x_q > y_q) begin
          x_d = x_q - y_q;
        end else begin
          y_d = y_q - x_q;
        end
        if (calc_done_s) begin
          res_d     = gcd_s;
          res_vld_d = 1'b1;
          tx_sh_d   = {1'b1, gcd_s, 1'b0};
          tx_cnt_d  = {CW{1'b0}};
          tx_idx_d  = 4'd0;
          st_d      = SEND;
        end else begin
          st_d = CALC;
        end
      end
      SEND: begin
        if (tx_cnt_q == BIT_END) begin
          tx_cnt_d = {CW{1'b0}};
          tx_sh_d  = {1'b1, tx_sh_q[9:1]};
          if (tx_idx_q == 4'd9) begin
            st_d = IDLE;
          end else begin
            tx_idx_d = tx_idx_q + 4'd1;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      default: st_d = IDLE;
    endcase
    tx_d = (st_d == SEND) ? tx_sh_d[0] : 1'b1;
  end

  // Display and LED values, registered below
  always_comb begin
    sel_s     = sw_s2_q ? b_q : a_q;
    sel_vld_s = sw_s2_q ? b_vld_q : a_vld_q;
    dig4_d    = sel_vld_s ? hex7(sel_s[7:4]) : 7'h7F;
    dig3_d    = sel_vld_s ? hex7(sel_s[3:0]) : 7'h7F;
    dig2_d    = res_vld_q ? hex7(res_q[7:4]) : 7'h7F;
    dig1_d    = res_vld_q ? hex7(res_q[3:0]) : 7'h7F;
`ifdef LED_STATUS_EN
    led_d = {3'b000, ferr_q, (st_q == SEND), (st_q == CALC), b_vld_q, a_vld_q};
`else
    led_d = res_q;
`endif
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
      sw_s1_q   <= 1'b0;
      sw_s2_q   <= 1'b0;
      rx_st_q   <= RX_IDLE;
      rx_cnt_q  <= {CW{1'b0}};
      rx_idx_q  <= 3'd0;
      rx_sh_q   <= 8'h00;
      rx_vld_q  <= 1'b0;
      ferr_q    <= 1'b0;
      st_q      <= IDLE;
      a_q       <= 8'h00;
      b_q       <= 8'h00;
      a_vld_q   <= 1'b0;
      b_vld_q   <= 1'b0;
      x_q       <= 8'h00;
      y_q       <= 8'h00;
      res_q     <= 8'h00;
      res_vld_q <= 1'b0;
      tx_sh_q   <= 10'h3FF;
      tx_cnt_q  <= {CW{1'b0}};
      tx_idx_q  <= 4'd0;
      tx_q      <= 1'b1;
      led_q     <= 8'h00;
      dig1_q    <= 7'h7F;
      dig2_q    <= 7'h7F;
      dig3_q    <= 7'h7F;
      dig4_q    <= 7'h7F;
    end else begin
      rx_s1_q   <= UART_RX;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
      sw_s1_q   <= switch[0];
      sw_s2_q   <= sw_s1_q;
      rx_st_q   <= rx_st_d;
      rx_cnt_q  <= rx_cnt_d;
      rx_idx_q  <= rx_idx_d;
      rx_sh_q   <= rx_sh_d;
      rx_vld_q  <= rx_vld_d;
      ferr_q    <= ferr_d;
      st_q      <= st_d;
      a_q       <= a_d;
      b_q       <= b_d;
      a_vld_q   <= a_vld_d;
      b_vld_q   <= b_vld_d;
      x_q       <= x_d;
      y_q       <= y_d;
      res_q     <= res_d;
      res_vld_q <= res_vld_d;
      tx_sh_q   <= tx_sh_d;
      tx_cnt_q  <= tx_cnt_d;
      tx_idx_q  <= tx_idx_d;
      tx_q      <= tx_d;
      led_q     <= led_d;
      dig1_q    <= dig1_d;
      dig2_q    <= dig2_d;
      dig3_q    <= dig3_d;
      dig4_q    <= dig4_d;
    end
  end

  assign UART_TX = tx_q;
  assign led     = led_q;
  assign digi1   = dig1_q;
  assign digi2   = dig2_q;
  assign digi3   = dig3_q;
  assign digi4   = dig4_q;

endmodule

// File: tb/tb_cpu_top.sv
// Scoreboard bench for cpu_top: expected TX frames are queued when operand B is sent and popped when a frame arrives.
module tb_cpu_top;

  localparam int BAUD   = 16;
  localparam int CLK_NS = 10;
  localparam int BIT_NS = BAUD * CLK_NS;
  localparam logic [6:0] SEG [0:15] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  localparam logic [7:0] TA [0:4] = '{8'h30, 8'hFF, 8'h01, 8'hE0, 8'h9B};
  localparam logic [7:0] TB [0:4] = '{8'h12, 8'hFF, 8'h80, 8'h38, 8'h5D};

  logic       sysclk = 1'b0;
  logic       reset  = 1'b1;
  logic [7:0] switch = 8'h00;
  logic       UART_RX = 1'b1;
  logic [7:0] led;
  logic [6:0] digi1, digi2, digi3, digi4;
  logic       UART_TX;

  int checks   = 0;
  int failures = 0;
  logic [9:0] exp_q [$];
  logic [9:0] got_q [$];
  logic [9:0] mon_f;

  cpu_top #(.BAUD_DIV(BAUD)) dut (
    .sysclk (sysclk),
    .reset  (reset),
    .led    (led),
    .switch (switch),
    .digi1  (digi1),
    .digi2  (digi2),
    .digi3  (digi3),
    .digi4  (digi4),
    .UART_RX(UART_RX),
    .UART_TX(UART_TX)
  );

  always #(CLK_NS / 2) sysclk = ~sysclk;

  // TX monitor: samples each frame mid-bit and pushes the 10 bits (bit0 = start)
  initial begin
    forever begin
      @(negedge UART_TX);
      if (reset) begin
        #(BIT_NS / 2);
        for (int i = 0; i < 10; i++) begin
          mon_f[i] = UART_TX;
          if (i < 9) #(BIT_NS);
        end
        got_q.push_back(mon_f);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] gcd_model(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] t;
    if (a == 8'd0) return b;
    while (b != 8'd0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  task automatic send_byte(input logic [7:0] d, input logic stop);
    UART_RX = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 8; i++) begin
      UART_RX = d[i];
      #(BIT_NS);
    end
    UART_RX = stop;
    #(BIT_NS);
    UART_RX = 1'b1;
    #(BIT_NS);
  endtask

  task automatic get_frame(output logic [9:0] f, output bit got);
    got = 1'b0;
    f   = 10'h000;
    for (int i = 0; i < 8000 && !got; i++) begin
      if (got_q.size() > 0) begin
        f   = got_q.pop_front();
        got = 1'b1;
      end else begin
        @(posedge sysclk);
      end
    end
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    #5;
    checks++; if (UART_TX !== 1'b1) begin failures++; $display("FAIL rst_tx got=%b exp=1", UART_TX); end
    checks++; if (led !== 8'h00) begin failures++; $display("FAIL rst_led got=%h exp=00", led); end
    checks++; if ({digi4, digi3, digi2, digi1} !== {4{7'h7F}}) begin failures++;
      $display("FAIL rst_digits got=%h %h %h %h exp=7f", digi4, digi3, digi2, digi1); end
    #5 reset = 1'b1;
    repeat (20) @(posedge sysclk);
    #1;
    checks++; if (UART_TX !== 1'b1) begin failures++; $display("FAIL idle_tx got=%b exp=1", UART_TX); end
    checks++; if ({digi4, digi3, digi2, digi1, led} !== {{4{7'h7F}}, 8'h00}) begin failures++;
      $display("FAIL idle_outputs got=%h %h %h %h led=%h exp=7f/00", digi4, digi3, digi2, digi1, led); end
  endtask

  task automatic test_gcd_basic();
    logic [9:0] f, e;
    bit got;
    send_byte(8'h1B, 1'b1);
    exp_q.push_back({1'b1, 8'h03, 1'b0});
    send_byte(8'h78, 1'b1);
    get_frame(f, got);
    e = exp_q.pop_front();
    checks++; if (!got || f !== e) begin failures++; $display("FAIL basic_frame got=%b exp=%b rcvd=%0d", f, e, got); end
    repeat (5) @(posedge sysclk);
    #1;
    checks++; if (digi2 !== SEG[0] || digi1 !== SEG[3]) begin failures++;
      $display("FAIL basic_result_digits got=%h %h exp=40 30", digi2, digi1); end
    checks++; if (digi4 !== SEG[1] || digi3 !== SEG[11]) begin failures++;
      $display("FAIL basic_a_digits got=%h %h exp=79 03", digi4, digi3); end
    checks++; if (led !== 8'h03) begin failures++; $display("FAIL basic_led got=%h exp=03", led); end
    switch = 8'hFF;
    repeat (6) @(posedge sysclk);
    #1;
    checks++; if (digi4 !== SEG[7] || digi3 !== SEG[8]) begin failures++;
      $display("FAIL switch_b_digits got=%h %h exp=78 00", digi4, digi3); end
    checks++; if (digi2 !== SEG[0] || digi1 !== SEG[3] || led !== 8'h03) begin failures++;
      $display("FAIL switch_ignored got=%h %h led=%h exp=40 30 03", digi2, digi1, led); end
    switch = 8'hFE;
    repeat (6) @(posedge sysclk);
    #1;
    checks++; if (digi4 !== SEG[1] || digi3 !== SEG[11]) begin failures++;
      $display("FAIL switch_upper_ignored got=%h %h exp=79 03", digi4, digi3); end
    switch = 8'h00;
  endtask

  task automatic test_zero_operands();
    logic [9:0] f, e;
    bit got;
    logic [7:0] za [0:2];
    logic [7:0] zb [0:2];
    za = '{8'h00, 8'h2A, 8'h00};
    zb = '{8'h0C, 8'h00, 8'h00};
    for (int k = 0; k < 3; k++) begin
      send_byte(za[k], 1'b1);
      exp_q.push_back({1'b1, gcd_model(za[k], zb[k]), 1'b0});
      send_byte(zb[k], 1'b1);
      get_frame(f, got);
      e = exp_q.pop_front();
      checks++; if (!got || f !== e) begin failures++;
        $display("FAIL zero_frame_%0d got=%b exp=%b rcvd=%0d", k, f, e, got); end
      if (k == 0) begin
        checks++; if (f !== 10'b1000011000) begin failures++;
          $display("FAIL zero_bits got=%b exp=1000011000", f); end
      end
    end
    repeat (5) @(posedge sysclk);
    #1;
    checks++; if ({digi4, digi3, digi2, digi1} !== {4{SEG[0]}}) begin failures++;
      $display("FAIL zero_digits got=%h %h %h %h exp=40", digi4, digi3, digi2, digi1); end
  endtask

  task automatic test_framing();
    logic [9:0] f, e;
    bit got;
    send_byte(8'h55, 1'b0);
    #(2 * BIT_NS);
    checks++; if (got_q.size() != 0) begin failures++;
      $display("FAIL ferr_no_frame got=%0d exp=0", got_q.size()); end
    checks++; if (digi4 !== SEG[0] || digi3 !== SEG[0]) begin failures++;
      $display("FAIL ferr_a_unchanged got=%h %h exp=40 40", digi4, digi3); end
`ifdef LED_STATUS_EN
    checks++; if (led[4] !== 1'b1) begin failures++; $display("FAIL ferr_led got=%b exp=1", led[4]); end
`else
    checks++; if (led !== 8'h00) begin failures++; $display("FAIL ferr_led got=%h exp=00", led); end
`endif
    send_byte(8'h09, 1'b1);
    exp_q.push_back({1'b1, 8'h03, 1'b0});
    send_byte(8'h06, 1'b1);
    get_frame(f, got);
    e = exp_q.pop_front();
    checks++; if (!got || f !== e) begin failures++; $display("FAIL ferr_next_frame got=%b exp=%b rcvd=%0d", f, e, got); end
  endtask

  task automatic test_dropped_bytes();
    logic [9:0] f, e;
    bit got;
    send_byte(8'hFF, 1'b1);
    exp_q.push_back({1'b1, 8'h01, 1'b0});
    send_byte(8'h01, 1'b1);
    send_byte(8'h07, 1'b1);
    get_frame(f, got);
    e = exp_q.pop_front();
    checks++; if (!got || f !== e) begin failures++; $display("FAIL drop_long_frame got=%b exp=%b rcvd=%0d", f, e, got); end
    send_byte(8'h0A, 1'b1);
    exp_q.push_back({1'b1, 8'h02, 1'b0});
    send_byte(8'h04, 1'b1);
    get_frame(f, got);
    e = exp_q.pop_front();
    checks++; if (!got || f !== e) begin failures++; $display("FAIL drop_next_frame got=%b exp=%b rcvd=%0d", f, e, got); end
    repeat (5) @(posedge sysclk);
    #1;
    checks++; if (digi4 !== SEG[0] || digi3 !== SEG[10]) begin failures++;
      $display("FAIL drop_a_digits got=%h %h exp=40 08", digi4, digi3); end
  endtask

  task automatic test_gcd_table();
    logic [9:0] f, e;
    bit got;
    logic [7:0] a, b;
    for (int k = 0; k < 7; k++) begin
      if (k < 5) begin
        a = TA[k];
        b = TB[k];
      end else begin
        a = 8'($urandom_range(255, 1));
        b = 8'($urandom_range(255, 1));
      end
      send_byte(a, 1'b1);
      exp_q.push_back({1'b1, gcd_model(a, b), 1'b0});
      send_byte(b, 1'b1);
      get_frame(f, got);
      e = exp_q.pop_front();
      checks++; if (!got || f !== e) begin failures++;
        $display("FAIL table_%0d a=%h b=%h got=%b exp=%b rcvd=%0d", k, a, b, f, e, got); end
    end
  endtask

  task automatic test_reset_mid_tx();
    logic [9:0] f, e;
    bit got;
    bit seen;
    send_byte(8'h1B, 1'b1);
    send_byte(8'h78, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      if (UART_TX === 1'b0) seen = 1'b1;
      else @(posedge sysclk);
    end
    checks++; if (!seen) begin failures++; $display("FAIL midtx_start got=none exp=start_bit"); end
    #(3 * BIT_NS + 3);
    reset = 1'b0;
    #1;
    checks++; if (UART_TX !== 1'b1) begin failures++; $display("FAIL midtx_tx got=%b exp=1", UART_TX); end
    checks++; if ({digi4, digi3, digi2, digi1, led} !== {{4{7'h7F}}, 8'h00}) begin failures++;
      $display("FAIL midtx_outputs got=%h %h %h %h led=%h exp=7f/00", digi4, digi3, digi2, digi1, led); end
    #9 reset = 1'b1;
    #(12 * BIT_NS);
    got_q.delete();
    checks++; if (UART_TX !== 1'b1) begin failures++; $display("FAIL midtx_idle got=%b exp=1", UART_TX); end
    for (int k = 0; k < 2; k++) begin
      send_byte(k == 0 ? 8'h30 : 8'h1B, 1'b1);
      exp_q.push_back({1'b1, (k == 0 ? 8'h06 : 8'h03), 1'b0});
      send_byte(k == 0 ? 8'h12 : 8'h78, 1'b1);
      get_frame(f, got);
      e = exp_q.pop_front();
      checks++; if (!got || f !== e) begin failures++;
        $display("FAIL midtx_after_%0d got=%b exp=%b rcvd=%0d", k, f, e, got); end
    end
  endtask

  initial begin
    test_reset();
    test_gcd_basic();
    test_zero_operands();
    test_framing();
    test_dropped_bytes();
    test_gcd_table();
    test_reset_mid_tx();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_top.md
CPU_TOP -- requirements
Module: cpu_top

Interface
REQ-001 Parameter BAUD_DIV, default 5208, meaning sysclk cycles per UART bit (50 MHz / 9600 baud).
REQ-002 sysclk  input  1  system clock, rising-edge, 50 MHz nominal.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 led  output  8  LED bank.
REQ-005 switch  input  8  user switches, asynchronous to sysclk.
REQ-006 digi1, digi2, digi3, digi4  output  7 each  7-seg digits, active-low, bit0=a through bit6=g.
REQ-007 UART_RX  input  1  serial in, 8N1, idle high.
REQ-008 UART_TX  output  1  serial out, 8N1, idle high.

Function
REQ-009 UART_RX SHALL pass through a 2-flop synchronizer before use.
REQ-010 RX SHALL detect a start bit on a high-to-low edge, recheck low at BAUD_DIV/2, then sample 8 data bits LSB-first at BAUD_DIV intervals, mid-bit.
REQ-011 If the start bit reads high at the recheck, RX SHALL return to idle with no byte delivered.
REQ-012 If the stop bit samples low, the byte SHALL be discarded and the sticky framing-error flag set.
REQ-013 Control FSM states: IDLE, HAVE_A, CALC, SEND.
REQ-014 Transitions: IDLE -> HAVE_A on a valid byte (latched as A); HAVE_A -> CALC on the next valid byte (latched as B); CALC -> SEND when GCD is done; SEND -> IDLE when the stop bit completes.
REQ-015 Bytes completing while in CALC or SEND SHALL be dropped.
REQ-016 CALC SHALL perform one step per clock on 8-bit unsigned X, Y, initialized from A and B: if X>Y then X=X-Y; if Y>X then Y=Y-X; if X==Y then result=X and the step is done.
REQ-017 Zero operands: A=0 gives result B; B=0 gives result A; both zero gives result 0. Each resolves in one cycle.
REQ-018 CALC latency SHALL not exceed 256 cycles.
REQ-019 TX SHALL start the start bit within 2 clocks of entering SEND.
REQ-020 TX frame: 1 start bit (0), 8 data bits LSB-first, 1 stop bit (1), each held BAUD_DIV clocks.
REQ-021 digi4/digi3 SHALL show A as hex high/low nibble, or B instead while switch[0]=1.
REQ-022 digi2/digi1 SHALL show the last result as hex high/low nibble.
REQ-023 Any digit with no valid value SHALL be blank (7'h7F).
REQ-024 Hex segment codes: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E (hex, bit6..bit0).
REQ-025 switch[7:1] SHALL be ignored.

Reset
REQ-026 While reset=0, immediately: FSM=IDLE, A/B/result invalid, UART_TX=1, led=0, all digits=7'h7F, RX idle, framing flag=0.
REQ-027 Reset asserted mid-receive, mid-calculation or mid-transmit SHALL abort the operation with no partial byte delivered and TX forced high.

Configuration
REQ-028 Macro LED_STATUS_EN: when defined, led = {3'b0, framing_err, SEND, CALC, B valid, A valid}.
REQ-029 When LED_STATUS_EN is not defined, led SHALL show the last result byte (0 before the first result).

Verification
REQ-030 Reset pulse low 10 ns, then idle -> UART_TX=1, digits all 7F, led=0.
REQ-031 Send 27 (0x1B), then 120 (0x78), each at 104166 ns/bit -> TX frame carries 0x03; digi2/digi1=40/30; digi4/digi3=79/03; led=0x03 (macro undefined).
REQ-032 Same stimulus with switch[0]=1 -> digi4/digi3 show 0x78 (78/00).
REQ-033 Send 0x00, then 0x0C -> result 0x0C; TX frame 0,0,0,1,1,0,0,0,0,1.
REQ-034 Byte with stop bit forced low -> byte ignored; state unchanged; with LED_STATUS_EN, led[4]=1.
REQ-035 Assert reset mid-TX frame -> UART_TX=1 immediately; FSM=IDLE; the next two bytes compute normally.
